fxp_div_iter: RTL

- Iterative signed fixed-point divider with valid/ready handshakes on both sides.
- Trades latency for area against the pipelined divider: one restoring-division engine, reused for several cycles per operation.
- Adds backpressure, a divide-by-zero flag, and a configurable number of quotient bits per cycle.
- Sits between fixed-point datapath stages that tolerate variable latency.

---
 rtl/fxp_div_pkg.sv | 23 ++
 rtl/fxp_div_step.sv | 21 ++
 rtl/fxp_div_iter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fxp_div_pkg.sv
// Shared types and elaboration-time helpers for the iterative fixed-point divider.
// Optional fast path in the top is controlled by the FXP_DIV_FASTPATH_EN macro.
package fxp_div_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CALC   = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Iterations needed to resolve all quotient bits plus the guard bit.
    function automatic int calc_iters(input int woi, input int wof, input int steps);
        return (woi + wof + 1 + steps - 1) / steps;
    endfunction

    // Left shift of |A| that scales the integer quotient to WOF fraction bits.
    function automatic int align_shift(input int wof, input int wifb, input int wifa);
        return wof + wifb - wifa;
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One combinational restoring-division step: shift in one numerator bit, try to subtract.
// The incoming remainder is always below the divisor, so DW bits hold every result.
module fxp_div_step #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_rem,
    input  logic          i_nbit,
    input  logic [DW-1:0] i_div,
    output logic [DW-1:0] o_rem,
    output logic          o_qbit
);

    logic [DW:0]   w_sh;
    logic [DW-1:0] w_sub;

    assign w_sh   = {i_rem, i_nbit};
    assign o_qbit = (w_sh >= {1'b0, i_div});
    assign w_sub  = w_sh[DW-1:0] - i_div;
    assign o_rem  = o_qbit ? w_sub : w_sh[DW-1:0];

endmodule

// File: rtl/fxp_div_iter.sv
// Iterative signed fixed-point divider, STEPS quotient bits per cycle, with saturation.
// Define FXP_DIV_FASTPATH_EN to let zero dividends/divisors skip the iteration phase.
module fxp_div_iter
    import fxp_div_pkg::*;
#(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1,
    parameter int STEPS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIIA+WIFA-1:0] dividend,
    input  logic [WIIB+WIFB-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 overflow,
    output logic                 div_by_zero,
    output logic [2:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and out/flags hold while out_valid waits.

    localparam int WA   = WIIA + WIFA;
    localparam int WB   = WIIB + WIFB;
    localparam int WO   = WOI + WOF;
    localparam int N    = calc_iters(WOI, WOF, STEPS);
    localparam int NQ   = N * STEPS;
    localparam int T    = align_shift(WOF, WIFB, WIFA) + 1;
    localparam int TP   = (T > 0) ? T : 0;
    localparam int TN   = (T < 0) ? -T : 0;
    localparam int NUMW = WA + TP;
    localparam int DW   = WB + TN;
    localparam int CW   = (NUMW > DW) ? NUMW : DW;
    localparam int CNTW = $clog2(N + 1);

    localparam logic [NQ-1:0] LIM_P = NQ'((1 << (WO - 1)) - 1);
    localparam logic [NQ-1:0] LIM_N = NQ'(1 << (WO - 1));
    localparam logic [WO-1:0] MAX_P = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] MIN_N = {1'b1, {(WO-1){1'b0}}};

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [WO-1:0]   r_out;
    logic            r_ovf;
    logic            r_dz;
    logic [WA-1:0]   r_a;
    logic [WB-1:0]   r_b;
    logic            r_sign;
    logic            r_pre_ovf;
    logic [DW-1:0]   r_rem;
    logic [NQ-1:0]   r_nq;
    logic [CNTW-1:0] r_cnt;

    logic [WA-1:0]      w_abs_a;
    logic [WB-1:0]      w_abs_b;
    logic [NUMW-1:0]    w_num;
    logic [DW-1:0]      w_d;
    logic [NQ+NUMW-1:0] w_num_ext;
    logic [CW-1:0]      w_hi_c;
    logic [CW-1:0]      w_d_c;
    logic               w_pre_ovf;

    // Unsigned negation keeps the most negative input exact at full width.
    assign w_abs_a   = r_a[WA-1] ? -r_a : r_a;
    assign w_abs_b   = r_b[WB-1] ? -r_b : r_b;
    assign w_num     = NUMW'(w_abs_a) << TP;
    assign w_d       = DW'(w_abs_b) << TN;
    assign w_num_ext = {{NQ{1'b0}}, w_num};
    assign w_hi_c    = CW'(w_num_ext[NQ+NUMW-1:NQ]);
    assign w_d_c     = CW'(w_d);
    // Bits above the NQ iterated positions already reach the divisor: quotient too large.
    assign w_pre_ovf = (w_hi_c >= w_d_c);

    logic [DW-1:0]    w_rem [0:STEPS];
    logic [NQ-1:0]    w_nq  [0:STEPS];
    logic [STEPS-1:0] w_qb;

    assign w_rem[0] = r_rem;
    assign w_nq[0]  = r_nq;

    // Numerator bits leave the top of w_nq while quotient bits enter at the bottom.
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        fxp_div_step #(.DW(DW)) u_step (
            .i_rem  (w_rem[gi]),
            .i_nbit (w_nq[gi][NQ-1]),
            .i_div  (w_d),
            .o_rem  (w_rem[gi+1]),
            .o_qbit (w_qb[gi])
        );
        assign w_nq[gi+1] = {w_nq[gi][NQ-2:0], w_qb[gi]};
    end

    logic [NQ-1:0] w_mag;
    logic          w_sat;
    logic          w_dz;
    logic [WO-1:0] w_res;
    logic          w_res_ovf;

    assign w_mag = (ROUND != 0) ? ((r_nq >> 1) + NQ'(r_nq[0])) : (r_nq >> 1);
    assign w_sat = r_pre_ovf || (w_mag > (r_sign ? LIM_N : LIM_P));
    assign w_dz  = (r_b == '0);

    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        if (w_dz) begin
            w_res     = r_a[WA-1] ? MIN_N : MAX_P;
            w_res_ovf = 1'b1;
        end else if (w_sat) begin
            w_res     = r_sign ? MIN_N : MAX_P;
            w_res_ovf = 1'b1;
        end else begin
            w_res = r_sign ? -w_mag[WO-1:0] : w_mag[WO-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_pre_ovf   <= 1'b0;
            r_rem       <= '0;
            r_nq        <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= dividend;
                        r_b        <= divisor;
                        r_in_ready <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sign    <= r_a[WA-1] ^ r_b[WB-1];
                    r_pre_ovf <= w_pre_ovf;
                    r_rem     <= w_hi_c[DW-1:0];
                    r_nq      <= w_num_ext[NQ-1:0];
                    r_cnt     <= CNTW'(N);
`ifdef FXP_DIV_FASTPATH_EN
                    r_state   <= ((r_a == '0) || (r_b == '0)) ? S_FINISH : S_CALC;
`else
                    r_state   <= S_CALC;
`endif
                end
                S_CALC: begin
                    r_rem <= w_rem[STEPS];
                    r_nq  <= w_nq[STEPS];
                    r_cnt <= r_cnt - CNTW'(1);
                    if (r_cnt == CNTW'(1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_out       <= w_res;
                    r_ovf       <= w_res_ovf;
                    r_dz        <= w_dz;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out         = r_out;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dz;
    assign dbg_state   = r_state;

endmodule
